// File: rtl/pixel_stream_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_loader_pkg
// Description : Shared types and constants for the pixel stream loader.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_loader_pkg;

    localparam int DEFAULT_WIDTH   = 320;
    localparam int DEFAULT_HEIGHT  = 200;
    localparam int FRAME_PIXELS    = DEFAULT_WIDTH * DEFAULT_HEIGHT;
    localparam int BYTES_PER_PIXEL = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    typedef logic [23:0] rgb_t;

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_loader_if
// Description : Byte stream valid/ready handshake with start-of-frame marker.
// Revision    : 1.0 - initial release
// ============================================================================
interface pixel_stream_loader_if;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sof;
    logic       in_ready;

    modport master (
        output in_data,
        output in_valid,
        output in_sof,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  in_sof,
        output in_ready
    );

endinterface
`default_nettype wire

// File: rtl/pixel_stream_loader_packer.sv
`default_nettype none
// ============================================================================
// Module      : rgb_byte_packer
// Description : Collects three stream bytes into one 24-bit pixel word.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_byte_packer
    import pixel_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_byte,
    input  logic       i_load,
    input  logic       i_flush,
    output logic       o_pixel_valid,
    output rgb_t       o_pixel
);

    logic [1:0] r_lane;
    logic [7:0] r_b0;
    logic [7:0] r_b1;
    logic       w_last_lane;

    assign w_last_lane   = (r_lane == 2'(BYTES_PER_PIXEL - 1));
    // Word is presented while the third byte is still on the bus; the
    // consumer registers it on the same edge that accepts that byte.
    assign o_pixel_valid = i_load & ~i_flush & w_last_lane;
    assign o_pixel       = {i_byte, r_b1, r_b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= 2'd0;
            r_b0   <= 8'd0;
            r_b1   <= 8'd0;
        end else if (i_load) begin
            if (i_flush) begin
                r_b0   <= i_byte;
                r_lane <= 2'd1;
            end else begin
                case (r_lane)
                    2'd0: begin
                        r_b0   <= i_byte;
                        r_lane <= 2'd1;
                    end
                    2'd1: begin
                        r_b1   <= i_byte;
                        r_lane <= 2'd2;
                    end
                    default: r_lane <= 2'd0;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_loader
// Description : Loads a packed RGB byte stream into a double-buffered pixel
//               memory and swaps banks on vsync after each complete frame.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_loader
    import pixel_loader_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_stream_loader_if.slave  s_in,
    input  logic                  vsync,
    output logic                  wr_en,
    output logic                  wr_bank,
    output logic [ADDR_W-1:0]     wr_addr,
    output rgb_t                  wr_data,
    output logic                  rd_bank,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam logic [ADDR_W-1:0] c_LAST_PIX = ADDR_W'(frame_pixels(WIDTH, HEIGHT) - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pix;
    logic                r_vsync_d;
    logic                r_wr_en;
    logic                r_wr_bank;
    logic [ADDR_W-1:0]   r_wr_addr;
    rgb_t                r_wr_data;
    logic                r_rd_bank;
    logic                r_frame_done;
    logic                r_frame_err;

    logic                w_accept;
    logic                w_load;
    logic                w_pixel_valid;
    rgb_t                w_pixel;

    assign s_in.in_ready = (r_state != WAIT_SWAP) & ~reset;
    assign w_accept      = s_in.in_valid & s_in.in_ready;
    // In IDLE only a start-of-frame byte is taken into the packer.
    assign w_load        = w_accept & ((r_state == LOAD) | s_in.in_sof);

    rgb_byte_packer u_packer (
        .clk           (clk),
        .rst           (reset),
        .i_byte        (s_in.in_data),
        .i_load        (w_load),
        .i_flush       (s_in.in_sof),
        .o_pixel_valid (w_pixel_valid),
        .o_pixel       (w_pixel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_pix        <= '0;
            r_vsync_d    <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_bank    <= 1'b1;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_rd_bank    <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_vsync_d    <= vsync;
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept && s_in.in_sof) begin
                        r_pix   <= '0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_accept && s_in.in_sof) begin
                        r_frame_err <= 1'b1;
                        r_pix       <= '0;
                    end else if (w_pixel_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_pix;
                        r_wr_data <= w_pixel;
                        if (r_pix == c_LAST_PIX) begin
                            r_frame_done <= 1'b1;
                            r_pix        <= '0;
                            r_state      <= WAIT_SWAP;
                        end else begin
                            r_pix <= r_pix + ADDR_W'(1);
                        end
                    end
                end
                WAIT_SWAP: begin
                    // Only an edge seen while already waiting counts.
                    if (vsync && !r_vsync_d) begin
                        r_rd_bank <= r_wr_bank;
                        r_wr_bank <= ~r_wr_bank;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_bank    = r_wr_bank;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign rd_bank    = r_rd_bank;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_stream_loader
// Description : Scoreboard bench for pixel_stream_loader (4x2 frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_loader;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int AW = 16;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vsync = 1'b0;
    logic          wr_en;
    logic          wr_bank;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          rd_bank;
    logic          frame_done;
    logic          frame_err;

    pixel_stream_loader_if bus ();

    pixel_stream_loader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_in       (bus),
        .vsync      (vsync),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_bank    (rd_bank),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          addr;
        logic [23:0] data;
        logic        bank;
        logic        done;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  m_part[$];
    logic        m_waiting, m_in_frame, m_wbank, m_rbank, m_vprev, m_err;
    int          m_pix;
    int          m_last_addr;
    logic [23:0] m_last_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: frame = stream of bytes, every 3 bytes make a pixel.
    task automatic model_step();
        wr_t  e;
        logic vedge;
        m_err = 1'b0;
        if (reset) begin
            m_waiting   = 1'b0;
            m_in_frame  = 1'b0;
            m_wbank     = 1'b1;
            m_rbank     = 1'b0;
            m_vprev     = 1'b0;
            m_pix       = 0;
            m_last_addr = 0;
            m_last_data = 24'h0;
            m_part.delete();
            exp_q.delete();
        end else begin
            vedge   = vsync && !m_vprev;
            m_vprev = vsync;
            if (m_waiting) begin
                if (vedge) begin
                    m_rbank   = m_wbank;
                    m_wbank   = !m_wbank;
                    m_waiting = 1'b0;
                end
            end else if (bus.in_valid) begin
                if (bus.in_sof) begin
                    m_err = m_in_frame;
                    m_part.delete();
                    m_part.push_back(bus.in_data);
                    m_pix      = 0;
                    m_in_frame = 1'b1;
                end else if (m_in_frame) begin
                    m_part.push_back(bus.in_data);
                    if (m_part.size() == 3) begin
                        e.addr = m_pix;
                        e.data = {m_part[2], m_part[1], m_part[0]};
                        e.bank = m_wbank;
                        e.done = (m_pix == N - 1);
                        exp_q.push_back(e);
                        m_last_addr = m_pix;
                        m_last_data = e.data;
                        m_part.delete();
                        if (e.done) begin
                            m_pix      = 0;
                            m_in_frame = 1'b0;
                            m_waiting  = 1'b1;
                        end else begin
                            m_pix++;
                        end
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: every DUT output is compared on the falling edge.
    initial forever begin
        wr_t e;
        @(negedge clk);
        chk("in_ready",   32'(bus.in_ready), 32'(!reset && !m_waiting));
        chk("frame_err",  32'(frame_err),    32'(m_err));
        chk("wr_bank",    32'(wr_bank),      32'(m_wbank));
        chk("rd_bank",    32'(rd_bank),      32'(m_rbank));
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(wr_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr",    32'(wr_addr),    32'(e.addr));
                chk("wr_data",    32'(wr_data),    32'(e.data));
                chk("write_bank", 32'(wr_bank),    32'(e.bank));
                chk("frame_done", 32'(frame_done), 32'(e.done));
            end
        end else begin
            chk("missing_write", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            chk("frame_done_idle", 32'(frame_done), 32'd0);
            chk("wr_addr_hold", 32'(wr_addr), 32'(m_last_addr));
            chk("wr_data_hold", 32'(wr_data), 32'(m_last_data));
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic s);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = s;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic drive_rand(input logic [7:0] d, input logic s);
        bus.in_data = 8'($urandom);
        idle(int'($urandom_range(0, 2)));
        drive(d, s);
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        idle(2);
        vsync = 1'b0;
        idle(2);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = 8'h00;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Frame 1: bytes 0x00..0x17 back to back into bank 1.
        for (int i = 0; i < 24; i++) drive(8'(i), i == 0);
        idle(3);
        vsync_pulse();
        vsync_pulse();

        // Stray bytes in IDLE, then a frame that restarts on a mid-frame sof.
        for (int i = 0; i < 5; i++) drive(8'(8'hC0 + i), 1'b0);
        drive(8'h30, 1'b1);
        drive(8'h31, 1'b0);
        drive(8'h32, 1'b0);
        drive(8'h33, 1'b0);
        drive(8'hAA, 1'b1);
        for (int i = 0; i < 22; i++) drive(8'($urandom), 1'b0);
        // Final byte coincides with a vsync rising edge.
        vsync = 1'b1;
        drive(8'h5C, 1'b0);
        idle(2);
        vsync = 1'b0;
        idle(2);
        vsync_pulse();

        // Randomly paced frame.
        for (int i = 0; i < 24; i++) drive_rand(8'($urandom), i == 0);
        idle(2);
        vsync_pulse();

        // Reset after pixel 3 of a new frame.
        for (int i = 0; i < 13; i++) drive_rand(8'($urandom), i == 0);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(2);

        // Fresh frame after reset lands in bank 1 from address 0.
        for (int i = 0; i < 24; i++) drive_rand(8'($urandom), i == 0);
        idle(3);
        vsync_pulse();
        idle(3);

        chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
